bcd_serial_receiver: RTL

//   Receive end of the BCD result serial link. Hunts the incoming bit stream for the
//   8-bit sync word, then deserialises one 16-bit, 4-digit packed BCD result, MSB first.

---
 rtl/bcd_serial_receiver.sv | 115 +++++++++++
 1 files changed

// File: rtl/bcd_serial_receiver.sv
// bcd_serial_receiver: hunts a serial stream for the sync word, then deserialises one packed-BCD word per frame
module bcd_serial_receiver #(
  parameter logic [7:0] SYNC_WORD = 8'b1001_0110,
  parameter int         DATA_BITS = 16,
  parameter int         TIMEOUT   = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 serial_in_i,
  input  logic                 serial_valid_i,
  output logic [DATA_BITS-1:0] result_o,
  output logic                 result_valid_o,
  output logic                 digit_error_o,
  output logic                 frame_abort_o,
  output logic                 busy_o,
  output logic [7:0]           frame_count_o
);
  localparam int BW = $clog2(DATA_BITS);
  localparam int IW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {HUNT = 2'b00, RECEIVE = 2'b01} state_t;
  state_t               state_q, state_d;
  logic [7:0]           sync_q, sync_d, sync_next;
  logic [DATA_BITS-1:0] data_q, data_d, data_next;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic [DATA_BITS-1:0] result_q, result_d;
  logic                 rv_q, rv_d, de_q, de_d, fa_q, fa_d, busy_q, busy_d;
  logic [7:0]           fc_q, fc_d;
  function automatic logic bad_digit(input logic [DATA_BITS-1:0] w);
    logic e;
    e = 1'b0;
    for (int k = 0; k < DATA_BITS / 4; k++) e |= (w[4*k +: 4] > 4'd9);
    return e;
  endfunction
  assign sync_next = {sync_q[6:0], serial_in_i};
  assign data_next = {data_q[DATA_BITS-2:0], serial_in_i};
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    result_d  = result_q;
    rv_d      = 1'b0;
    de_d      = de_q;
    fa_d      = 1'b0;
    fc_d      = fc_q;
    case (state_q)
      HUNT: begin
        if (serial_valid_i) begin
          sync_d = (sync_next == SYNC_WORD) ? 8'd0 : sync_next;
          if (sync_next == SYNC_WORD) begin
            state_d   = RECEIVE;
            bit_cnt_d = '0;
            idle_d    = '0;
          end
        end
      end
      RECEIVE: begin
        if (serial_valid_i) begin
          data_d    = data_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          idle_d    = '0;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            result_d = data_next;
            rv_d     = 1'b1;
            de_d     = bad_digit(data_next);
            fc_d     = fc_q + 8'd1;
            state_d  = HUNT;
          end
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          fa_d    = 1'b1;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    busy_d = (state_d == RECEIVE);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= HUNT;
      sync_q    <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      de_q      <= 1'b0;
      fa_q      <= 1'b0;
      busy_q    <= 1'b0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      de_q      <= de_d;
      fa_q      <= fa_d;
      busy_q    <= busy_d;
      fc_q      <= fc_d;
    end
  end
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign digit_error_o  = de_q;
  assign frame_abort_o  = fa_q;
  assign busy_o         = busy_q;
  assign frame_count_o  = fc_q;
endmodule
